// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for the asynchronous FIFO controllers.
package fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 4;
   localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;
   localparam int OBUF_DEPTH      = 2;

   // Wide container so one helper serves any pointer width; callers truncate.
   typedef logic [31:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin = gray;
      for (int i = 1; i < 32; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchroniser for Gray-coded pointers crossing clock domains.
module fifo_sync_2ff
   import fifo_pkg::*;
#(
   parameter int WIDTH = FIFO_PTR_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Capture the foreign-domain value, then re-register it to settle metastability.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: pointers, empty flags, RAM read sequencing
// and a 2-entry valid/ready output buffer. Optional rd_level output under FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
   parameter int DATA_WIDTH    = 8,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [ADDR_WIDTH:0]   wr_ptr_gray_in,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray_out,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] rd_data_out,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  rd_empty,
   output logic                  rd_aempty
`ifdef FIFO_RD_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   rd_level
`endif
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0]         wq2;
   logic [PW-1:0]         rd_ptr_bin;
   logic [PW-1:0]         rd_ptr_bin_next;
   logic [PW-1:0]         wr_ptr_bin;
   logic [PW-1:0]         level;
   logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
   logic [1:0]            occupancy;
   logic                  inflight;
   logic                  empty_raw;
   logic                  pop;
   logic                  fetch;
   logic [2:0]            pending;

   fifo_sync_2ff #(.WIDTH(PW)) u_wr_ptr_sync (
      .clk (rd_clk),
      .rst (rd_rst),
      .d   (wr_ptr_gray_in),
      .q   (wq2)
   );

   // Fetch only while the buffer plus the word already in flight leaves a free slot.
   always_comb begin
      empty_raw       = (rd_ptr_gray_out == wq2);
      wr_ptr_bin      = PW'(gray2bin(ptr_word_t'(wq2)));
      level           = wr_ptr_bin - rd_ptr_bin;
      pop             = rd_valid & rd_ready;
      pending         = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
      fetch           = !empty_raw && (pending < 3'(OBUF_DEPTH));
      rd_ptr_bin_next = rd_ptr_bin + {{(PW-1){1'b0}}, 1'b1};
   end

   assign ram_rd_en   = fetch;
   assign ram_rd_addr = rd_ptr_bin[ADDR_WIDTH-1:0];
   assign rd_data_out = obuf[0];
   assign rd_valid    = (occupancy != 2'd0);
   assign rd_empty    = empty_raw;
   assign rd_aempty   = (level <= PW'(AEMPTY_THRESH));

   // Advance the read pointer on each RAM fetch; the Gray copy moves on the same edge.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         rd_ptr_bin      <= '0;
         rd_ptr_gray_out <= '0;
         inflight        <= 1'b0;
      end else begin
         inflight <= fetch;
         if (fetch) begin
            rd_ptr_bin      <= rd_ptr_bin_next;
            rd_ptr_gray_out <= PW'(bin2gray(ptr_word_t'(rd_ptr_bin_next)));
         end else begin
            rd_ptr_bin      <= rd_ptr_bin;
            rd_ptr_gray_out <= rd_ptr_gray_out;
         end
      end
   end

   // Output buffer: land the RAM word at the tail, pop from the head, both in one cycle if needed.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         occupancy <= 2'd0;
         obuf[0]   <= '0;
         obuf[1]   <= '0;
      end else begin
         case ({inflight, pop})
            2'b10: begin
               if (occupancy == 2'd0) begin
                  obuf[0] <= ram_rd_data;
               end else begin
                  obuf[1] <= ram_rd_data;
               end
               occupancy <= occupancy + 2'd1;
            end
            2'b01: begin
               obuf[0]   <= obuf[1];
               occupancy <= occupancy - 2'd1;
            end
            2'b11: begin
               if (occupancy == 2'd1) begin
                  obuf[0] <= ram_rd_data;
               end else begin
                  obuf[0] <= obuf[1];
                  obuf[1] <= ram_rd_data;
               end
            end
            default: begin
               occupancy <= occupancy;
            end
         endcase
      end
   end

`ifdef FIFO_RD_LEVEL_EN
   // Registered occupancy for the consumer; lags the internal level by one cycle.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         rd_level <= '0;
      end else begin
         rd_level <= level;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: RAM and write-side models, queue-based scoreboard.
module tb_fifo_rd_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 16;

   logic          rd_clk = 1'b0;
   logic          rd_rst = 1'b1;
   logic [PW-1:0] wr_ptr_gray_in = '0;
   logic [PW-1:0] rd_ptr_gray_out;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data = '0;
   logic [DW-1:0] rd_data_out;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic          rd_empty;
   logic          rd_aempty;
`ifdef FIFO_RD_LEVEL_EN
   logic [PW-1:0] rd_level;
`endif

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   int            wr_count  = 0;
   int            rd_issued = 0;
   int            errors    = 0;
   int            checks    = 0;

   fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AEMPTY_THRESH(2)) dut (
      .rd_clk          (rd_clk),
      .rd_rst          (rd_rst),
      .wr_ptr_gray_in  (wr_ptr_gray_in),
      .rd_ptr_gray_out (rd_ptr_gray_out),
      .ram_rd_en       (ram_rd_en),
      .ram_rd_addr     (ram_rd_addr),
      .ram_rd_data     (ram_rd_data),
      .rd_data_out     (rd_data_out),
      .rd_valid        (rd_valid),
      .rd_ready        (rd_ready),
      .rd_empty        (rd_empty),
      .rd_aempty       (rd_aempty)
`ifdef FIFO_RD_LEVEL_EN
      ,
      .rd_level        (rd_level)
`endif
   );

   always #5 rd_clk = ~rd_clk;

   // Synchronous RAM with one-cycle read latency.
   always @(posedge rd_clk) begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   function automatic logic [PW-1:0] to_gray(input int n);
      logic [PW-1:0] b;
      b = PW'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic tb_write(input logic [DW-1:0] data);
      mem[wr_count % DEPTH] = data;
      exp_q.push_back(data);
      wr_count++;
      wr_ptr_gray_in = to_gray(wr_count);
   endtask

   task automatic do_reset();
      @(negedge rd_clk);
      rd_rst = 1'b1;
      rd_ready = 1'b0;
      wr_ptr_gray_in = '0;
      wr_count = 0;
      rd_issued = 0;
      exp_q.delete();
      repeat (2) @(negedge rd_clk);
      rd_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", rd_empty); end
      checks++; if (rd_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", rd_aempty); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
      checks++; if (rd_ptr_gray_out !== 5'b00000) begin errors++; $display("FAIL reset_gray: got %b want 00000", rd_ptr_gray_out); end
      checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", ram_rd_en); end
      checks++; if (rd_data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rd_data_out); end
   endtask

   task automatic test_single();
      int            en_edge;
      int            val_edge;
      int            en_cnt;
      logic [AW-1:0] en_addr;
      logic [DW-1:0] got;
      en_edge = -1; val_edge = -1; en_cnt = 0; en_addr = '1; got = '0;
      @(negedge rd_clk);
      rd_ready = 1'b1;
      tb_write(8'hA5);
      for (int e = 1; e <= 8; e++) begin
         @(negedge rd_clk); #1;
         if (ram_rd_en) begin
            en_cnt++; rd_issued++;
            if (en_edge < 0) begin en_edge = e; en_addr = ram_rd_addr; end
         end
         if (rd_valid && val_edge < 0) begin val_edge = e; got = rd_data_out; end
         if (rd_valid && rd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      checks++; if (en_cnt != 1) begin errors++; $display("FAIL single_en_count: got %0d want 1", en_cnt); end
      checks++; if (en_addr !== 4'd0) begin errors++; $display("FAIL single_addr: got %0d want 0", en_addr); end
      checks++; if (en_edge != 2) begin errors++; $display("FAIL single_fetch_latency: got %0d want 2", en_edge); end
      checks++; if (val_edge != 4) begin errors++; $display("FAIL single_valid_latency: got %0d want 4", val_edge); end
      checks++; if (got !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", got); end
      checks++; if (rd_empty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL single_after_pop: got empty=%b valid=%b want 1/0", rd_empty, rd_valid); end
      checks++; if (rd_ptr_gray_out !== 5'b00001) begin errors++; $display("FAIL single_gray: got %b want 00001", rd_ptr_gray_out); end
   endtask

   task automatic test_stream();
      int            vcnt;
      int            first;
      int            last;
      logic [DW-1:0] want;
      vcnt = 0; first = -1; last = -1;
      do_reset();
      @(negedge rd_clk);
      for (int i = 0; i < 16; i++) tb_write(DW'($urandom));
      rd_ready = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(negedge rd_clk); #1;
         if (ram_rd_en) begin
            checks++;
            if (ram_rd_addr !== AW'(rd_issued) || rd_issued >= wr_count) begin
               errors++; $display("FAIL stream_addr: got %0d want %0d (issued %0d written %0d)", ram_rd_addr, AW'(rd_issued), rd_issued, wr_count);
            end
            rd_issued++;
         end
         if (rd_valid && rd_ready) begin
            want = (exp_q.size() != 0) ? exp_q[0] : 'x;
            checks++;
            if (exp_q.size() == 0 || rd_data_out !== want) begin errors++; $display("FAIL stream_data: got %h want %h", rd_data_out, want); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            vcnt++; if (first < 0) first = e; last = e;
         end
      end
      checks++; if (vcnt != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", vcnt); end
      checks++; if (last - first != 15) begin errors++; $display("FAIL stream_bubbles: got span %0d want 15", last - first); end
      checks++; if (rd_ptr_gray_out !== 5'b11000) begin errors++; $display("FAIL stream_gray: got %b want 11000", rd_ptr_gray_out); end
      checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", rd_empty); end
   endtask

   task automatic test_backpressure();
      int            en_cnt;
      int            pops;
      logic          seen;
      logic [DW-1:0] want;
      en_cnt = 0; pops = 0; seen = 1'b0;
      @(negedge rd_clk);
      rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) tb_write(DW'($urandom));
      for (int e = 1; e <= 12; e++) begin
         @(negedge rd_clk); #1;
         if (ram_rd_en) begin
            en_cnt++;
            checks++;
            if (ram_rd_addr !== AW'(rd_issued)) begin errors++; $display("FAIL bp_addr: got %0d want %0d", ram_rd_addr, AW'(rd_issued)); end
            rd_issued++;
         end
         if (seen) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data_out !== exp_q[0]) begin
               errors++; $display("FAIL bp_hold: got valid=%b data=%h want 1/%h", rd_valid, rd_data_out, exp_q[0]);
            end
         end
         if (rd_valid) seen = 1'b1;
      end
      checks++; if (en_cnt != 2) begin errors++; $display("FAIL bp_stall_fetches: got %0d want 2", en_cnt); end
      checks++; if (rd_empty !== 1'b0 || rd_aempty !== 1'b0) begin errors++; $display("FAIL bp_flags: got empty=%b aempty=%b want 0/0", rd_empty, rd_aempty); end
      @(negedge rd_clk);
      rd_ready = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         if (e > 1) @(negedge rd_clk);
         #1;
         if (ram_rd_en) begin
            en_cnt++;
            checks++;
            if (ram_rd_addr !== AW'(rd_issued) || rd_issued >= wr_count) begin errors++; $display("FAIL bp_addr: got %0d want %0d", ram_rd_addr, AW'(rd_issued)); end
            rd_issued++;
         end
         if (rd_valid && rd_ready) begin
            want = (exp_q.size() != 0) ? exp_q[0] : 'x;
            checks++;
            if (exp_q.size() == 0 || rd_data_out !== want) begin errors++; $display("FAIL bp_data: got %h want %h", rd_data_out, want); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            pops++;
         end
      end
      checks++; if (pops != 5) begin errors++; $display("FAIL bp_pops: got %0d want 5", pops); end
      checks++; if (en_cnt != 5) begin errors++; $display("FAIL bp_total_fetches: got %0d want 5", en_cnt); end
   endtask

   task automatic test_wrap();
      int            n_addr;
      logic [AW-1:0] addrs [4];
      logic [PW-1:0] gray_before;
      logic [DW-1:0] want;
      n_addr = 0;
      do_reset();
      @(negedge rd_clk);
      for (int i = 0; i < 15; i++) tb_write(DW'($urandom));
      rd_ready = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(negedge rd_clk); #1;
         if (ram_rd_en) rd_issued++;
         if (rd_valid && rd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      gray_before = rd_ptr_gray_out;
      checks++; if (gray_before[PW-1] !== 1'b0 || rd_issued != 15) begin errors++; $display("FAIL wrap_pre_msb: got gray=%b issued=%0d want msb 0, 15", gray_before, rd_issued); end
      @(negedge rd_clk);
      tb_write(8'h5A);
      tb_write(8'hC3);
      for (int e = 1; e <= 12; e++) begin
         @(negedge rd_clk); #1;
         checks++; if (rd_aempty !== 1'b1) begin errors++; $display("FAIL wrap_aempty: got %b want 1", rd_aempty); end
         if (ram_rd_en) begin
            if (n_addr < 4) addrs[n_addr] = ram_rd_addr;
            n_addr++; rd_issued++;
         end
         if (rd_valid && rd_ready) begin
            want = (exp_q.size() != 0) ? exp_q[0] : 'x;
            checks++;
            if (exp_q.size() == 0 || rd_data_out !== want) begin errors++; $display("FAIL wrap_data: got %h want %h", rd_data_out, want); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      checks++; if (n_addr != 2) begin errors++; $display("FAIL wrap_fetches: got %0d want 2", n_addr); end
      checks++; if (addrs[0] !== 4'd15 || addrs[1] !== 4'd0) begin errors++; $display("FAIL wrap_addr_seq: got %0d,%0d want 15,0", addrs[0], addrs[1]); end
      checks++; if (rd_ptr_gray_out !== to_gray(17) || rd_ptr_gray_out[PW-1] !== 1'b1) begin errors++; $display("FAIL wrap_gray: got %b want %b", rd_ptr_gray_out, to_gray(17)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d words want 0", exp_q.size()); end
   endtask

   task automatic test_midop_reset();
      int   found;
      logic stale;
      found = 0; stale = 1'b0;
      do_reset();
      @(negedge rd_clk);
      rd_ready = 1'b1;
      tb_write(8'h3C);
      for (int e = 1; e <= 10 && found == 0; e++) begin
         @(negedge rd_clk); #1;
         if (ram_rd_en) found = e;
      end
      checks++; if (found == 0) begin errors++; $display("FAIL midrst_fetch_timeout: got no fetch want one within 10 cycles"); end
      @(negedge rd_clk);
      rd_rst = 1'b1;
      wr_ptr_gray_in = '0;
      wr_count = 0; rd_issued = 0; exp_q.delete();
      @(negedge rd_clk); #1;
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rd_valid); end
      checks++; if (rd_data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", rd_data_out); end
      rd_rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge rd_clk); #1;
         if (rd_valid || ram_rd_en) stale = 1'b1;
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale: got activity=1 want 0"); end
      checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", rd_empty); end
   endtask

   task automatic test_random();
      logic [DW-1:0] want;
      do_reset();
      for (int c = 0; c < 440; c++) begin
         @(negedge rd_clk);
         rd_ready = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (c < 400 && $urandom_range(0, 2) != 0 && (wr_count - rd_issued) < 14) tb_write(DW'($urandom));
         #1;
         if (ram_rd_en) begin
            checks++;
            if (ram_rd_addr !== AW'(rd_issued) || rd_issued >= wr_count) begin
               errors++; $display("FAIL rand_addr: got %0d want %0d (issued %0d written %0d)", ram_rd_addr, AW'(rd_issued), rd_issued, wr_count);
            end
            rd_issued++;
         end
         if (rd_valid && rd_ready) begin
            want = (exp_q.size() != 0) ? exp_q[0] : 'x;
            checks++;
            if (exp_q.size() == 0 || rd_data_out !== want) begin errors++; $display("FAIL rand_data: got %h want %h", rd_data_out, want); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      checks++; if (exp_q.size() != 0 || rd_issued != wr_count) begin errors++; $display("FAIL rand_drain: got left=%0d issued=%0d want 0/%0d", exp_q.size(), rd_issued, wr_count); end
      checks++; if (rd_empty !== 1'b1 || rd_aempty !== 1'b1) begin errors++; $display("FAIL rand_flags: got empty=%b aempty=%b want 1/1", rd_empty, rd_aempty); end
      checks++; if (rd_ptr_gray_out !== to_gray(wr_count)) begin errors++; $display("FAIL rand_gray: got %b want %b", rd_ptr_gray_out, to_gray(wr_count)); end
`ifdef FIFO_RD_LEVEL_EN
      checks++; if (rd_level !== 5'd0) begin errors++; $display("FAIL rand_level: got %0d want 0", rd_level); end
`endif
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_midop_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
